// File: rtl/ck_rst_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// reset-cause codes and counter width calculation.
package ck_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_STABLE     = 3'd1,
    ST_REL_PERIPH = 3'd2,
    ST_RUN        = 3'd3,
    ST_SW_HOLD    = 3'd4
  } rst_state_t;

  localparam int unsigned CAUSE_W = 2;

  localparam logic [CAUSE_W-1:0] CAUSE_POR  = 2'b00;
  localparam logic [CAUSE_W-1:0] CAUSE_LOCK = 2'b01;
  localparam logic [CAUSE_W-1:0] CAUSE_SW   = 2'b10;
  localparam logic [CAUSE_W-1:0] CAUSE_WDT  = 2'b11;

  // One spare bit above the largest terminal count so the counter cannot wrap.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_sync2.sv
// Two-flop level synchronizer for an asynchronous input, cleared
// asynchronously by an active-high reset.
module rst_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sys_rst_seq.sv
// Reset sequencer: qualifies PLL lock, then releases peripheral and core
// resets in order; handles lock loss and software resets.
// Optional watchdog reset source enabled by defining WDT_RST_EN.
module sys_rst_seq
  import ck_rst_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC = 16,
  parameter int unsigned CORE_DELAY_CYC  = 8,
  parameter int unsigned SW_HOLD_CYC     = 4
`ifdef WDT_RST_EN
  ,
  parameter int unsigned WDT_TIMEOUT     = 1024
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
`ifdef WDT_RST_EN
  input  logic               wdt_kick,
`endif
  output logic               periph_rst_n,
  output logic               core_rst_n,
  output logic               rst_busy,
  output logic [CAUSE_W-1:0] rst_cause
);

  localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYC, CORE_DELAY_CYC, SW_HOLD_CYC);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_HOLD_CYC - 1);

  rst_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               periph_rst_n_q, periph_rst_n_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               rst_busy_q, rst_busy_d;
  logic               lock_s;
  logic               wdt_expire;

  rst_sync2 u_lock_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

`ifdef WDT_RST_EN
  localparam int unsigned WDT_W = $clog2(WDT_TIMEOUT) + 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  // Watchdog counts only while running; kicks and leaving RUN clear it.
  always_comb begin
    wdt_expire = (state_q == ST_RUN) && (wdt_q == WDT_LAST);
    wdt_d      = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !wdt_kick) begin
      wdt_d = wdt_q + WDT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_expire = 1'b0;
`endif

  // State, sequencing counter and cause register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic; reset events override the per-state sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REL_PERIPH: begin
        if (cnt_q == CORE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
      end
      ST_SW_HOLD: begin
        if (cnt_q == SW_LAST) begin
          state_d = ST_REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    if ((state_q == ST_REL_PERIPH) || (state_q == ST_RUN) || (state_q == ST_SW_HOLD)) begin
      if (!lock_s) begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
        cause_d = CAUSE_LOCK;
      end else if (wdt_expire) begin
        state_d = ST_SW_HOLD;
        cnt_d   = '0;
        cause_d = CAUSE_WDT;
      end else if (sw_rst_req) begin
        state_d = ST_SW_HOLD;
        cnt_d   = '0;
        cause_d = CAUSE_SW;
      end
    end
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    periph_rst_n_d = (state_d == ST_REL_PERIPH) || (state_d == ST_RUN);
    core_rst_n_d   = (state_d == ST_RUN);
    rst_busy_d     = (state_d != ST_RUN);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      periph_rst_n_q <= 1'b0;
      core_rst_n_q   <= 1'b0;
      rst_busy_q     <= 1'b1;
    end else begin
      periph_rst_n_q <= periph_rst_n_d;
      core_rst_n_q   <= core_rst_n_d;
      rst_busy_q     <= rst_busy_d;
    end
  end

  assign periph_rst_n = periph_rst_n_q;
  assign core_rst_n   = core_rst_n_q;
  assign rst_busy     = rst_busy_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Directed bench for sys_rst_seq: expected release/assert edges are queued
// when stimulus is applied and compared when the outputs change.
module tb_sys_rst_seq;

  logic       sys_clk;
  logic       sys_rst;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       rst_busy;
  logic [1:0] rst_cause;
`ifdef WDT_RST_EN
  logic       wdt_kick;
`endif

  int edge_n = 0;
  int total  = 0;
  int bad    = 0;
  int exp_q[$];

`ifdef WDT_RST_EN
  sys_rst_seq #(.WDT_TIMEOUT(32)) dut (
`else
  sys_rst_seq dut (
`endif
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
`ifdef WDT_RST_EN
    .wdt_kick     (wdt_kick),
`endif
    .periph_rst_n (periph_rst_n),
    .core_rst_n   (core_rst_n),
    .rst_busy     (rst_busy),
    .rst_cause    (rst_cause)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) edge_n <= edge_n + 1;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return periph_rst_n === 1'b1;
      1:       return core_rst_n === 1'b1;
      2:       return rst_busy === 1'b0;
      3:       return periph_rst_n === 1'b0;
      4:       return core_rst_n === 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (bounded) for a condition, then compare its edge with the queued expectation.
  task automatic observe(input string tag, input int sel, input int budget);
    int got;
    int exp_e;
    got = -1;
    for (int i = 0; i <= budget; i++) begin
      if (cond(sel)) begin
        got = edge_n;
        break;
      end
      tick();
    end
    exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    check(tag, got, exp_e);
  endtask

  initial begin
    int e;
    int quiet;

    sys_rst    = 1'b1;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
`ifdef WDT_RST_EN
    wdt_kick   = 1'b1;
`endif
    repeat (5) tick();
    check("rst_periph", int'(periph_rst_n), 0);
    check("rst_core",   int'(core_rst_n),   0);
    check("rst_busy",   int'(rst_busy),     1);
    check("rst_cause",  int'(rst_cause),    0);

    // Power-up: lock present at the first edge after reset release.
    sys_rst    = 1'b0;
    pll_locked = 1'b1;
    e = edge_n;
    exp_q.push_back(e + 19);
    exp_q.push_back(e + 27);
    exp_q.push_back(e + 27);
    observe("pu_periph_rise", 0, 40);
    observe("pu_core_rise",   1, 20);
    observe("pu_busy_fall",   2, 5);
    check("pu_cause", int'(rst_cause), 0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    e = edge_n;
    exp_q.push_back(e + 3);
    exp_q.push_back(e + 3);
    observe("ll_periph_fall", 3, 10);
    observe("ll_core_fall",   4, 5);
    check("ll_cause", int'(rst_cause), 1);
    check("ll_busy",  int'(rst_busy),  1);

    // Re-lock with a 3-cycle glitch while STABLE counts 10.
    pll_locked = 1'b1;
    quiet = 0;
    repeat (13) begin
      tick();
      if (periph_rst_n !== 1'b0) quiet++;
    end
    pll_locked = 1'b0;
    repeat (3) begin
      tick();
      if (periph_rst_n !== 1'b0) quiet++;
    end
    pll_locked = 1'b1;
    check("glitch_quiet", quiet, 0);
    e = edge_n;
    exp_q.push_back(e + 19);
    exp_q.push_back(e + 27);
    observe("gl_periph_rise", 0, 40);
    observe("gl_core_rise",   1, 20);
    check("gl_cause", int'(rst_cause), 1);

    // Single-cycle software reset in RUN.
    sw_rst_req = 1'b1;
    e = edge_n;
    tick();
    sw_rst_req = 1'b0;
    check("sw_periph_low", int'(periph_rst_n), 0);
    check("sw_core_low",   int'(core_rst_n),   0);
    check("sw_cause",      int'(rst_cause),    2);
    exp_q.push_back(e + 5);
    exp_q.push_back(e + 13);
    observe("sw_periph_rise", 0, 20);
    observe("sw_core_rise",   1, 20);

    // Held request restarts the hold on every cycle it is seen.
    sw_rst_req = 1'b1;
    e = edge_n;
    repeat (3) tick();
    sw_rst_req = 1'b0;
    exp_q.push_back(e + 7);
    exp_q.push_back(e + 15);
    observe("swh_periph_rise", 0, 20);
    observe("swh_core_rise",   1, 20);

    // Lock loss and software request reach the FSM on the same edge.
    pll_locked = 1'b0;
    repeat (2) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("sim_cause",  int'(rst_cause),    1);
    check("sim_periph", int'(periph_rst_n), 0);
    check("sim_busy",   int'(rst_busy),     1);
    quiet = 0;
    repeat (8) begin
      tick();
      if (periph_rst_n !== 1'b0) quiet++;
    end
    check("sim_wait_lock", quiet, 0);
    pll_locked = 1'b1;
    e = edge_n;
    exp_q.push_back(e + 19);
    exp_q.push_back(e + 27);
    observe("sim_periph_rise", 0, 40);
    observe("sim_core_rise",   1, 20);

`ifdef WDT_RST_EN
    // Unserviced watchdog fires 32 edges after RUN entry.
    wdt_kick = 1'b0;
    e = edge_n;
    exp_q.push_back(e + 32);
    observe("wdt_periph_fall", 3, 50);
    check("wdt_cause", int'(rst_cause), 3);
    exp_q.push_back(e + 36);
    exp_q.push_back(e + 44);
    observe("wdt_periph_rise", 0, 20);
    observe("wdt_core_rise",   1, 20);
    quiet = 0;
    for (int i = 0; i < 500; i++) begin
      wdt_kick = (i % 20 == 0);
      tick();
      if (periph_rst_n !== 1'b1) quiet++;
    end
    wdt_kick = 1'b1;
    check("wdt_kicked_quiet", quiet, 0);
`endif

    // Asynchronous reset clears outputs between clock edges.
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    check("arst_periph", int'(periph_rst_n), 0);
    check("arst_core",   int'(core_rst_n),   0);
    check("arst_busy",   int'(rst_busy),     1);
    check("arst_cause",  int'(rst_cause),    0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
